word_mux_pipe: RTL and testbench

//  Parametrised, pipelined NUM_IN:1 word multiplexer with valid/ready handshake.

---
 rtl/wmux_pkg.sv | 20 ++
 rtl/mux2to1w.sv | 13 +
 rtl/word_mux_pipe.sv | 147 ++++++++++++++
 tb/tb_word_mux_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/wmux_pkg.sv
// Shared types and elaboration helpers for the pipelined word multiplexer.
package wmux_pkg;

  // Per-stage control that travels alongside the data words.
  typedef struct packed {
    logic valid;
    logic err;
  } stg_ctl_t;

  // Number of select bits, which equals the number of 2:1 tree levels.
  function automatic int sel_w(input int n);
    return $clog2(n);
  endfunction

  // Number of register stages needed to cover all tree levels.
  function automatic int num_stg(input int levels, input int lps);
    return (levels + lps - 1) / lps;
  endfunction

endpackage

// File: rtl/mux2to1w.sv
// Combinational 2:1 multiplexer for one WIDTH-bit word; the leaf cell of the tree.
module mux2to1w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] IN0,
  input  logic [WIDTH-1:0] IN1,
  input  logic             SEL,
  output logic [WIDTH-1:0] OUT
);

  assign OUT = SEL ? IN1 : IN0;

endmodule

// File: rtl/word_mux_pipe.sv
// Pipelined NUM_IN:1 word multiplexer with valid/ready handshake.
// The select tree is built from 2:1 word muxes, LSB of SEL at the first level,
// with a register stage after every LVL_PER_STG levels. Select bits not yet
// consumed travel down the pipe with the partially reduced data.
// Optional feature: define WMUX_PARITY_EN to add the registered OUT_PAR output.
module word_mux_pipe
  import wmux_pkg::*;
#(
  parameter int  WIDTH       = 32,
  parameter int  NUM_IN      = 32,
  parameter int  LVL_PER_STG = 2,
  localparam int SELW        = sel_w(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] IN,
  input  logic [SELW-1:0]         SEL,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        OUT,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
`ifdef WMUX_PARITY_EN
  ,
  output logic                    OUT_PAR
`endif
);

  localparam int            LEVELS   = SELW;
  localparam int            STAGES   = num_stg(LEVELS, LVL_PER_STG);
  localparam int            PAD_IN   = 2**SELW;
  localparam logic [SELW:0] NUM_IN_W = (SELW+1)'(NUM_IN);

  logic                    adv;
  logic                    sel_oob;
  logic [PAD_IN*WIDTH-1:0] in_pad;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // Out-of-range selects land on zero padding; flag them so the consumer knows.
  assign sel_oob = ({1'b0, SEL} >= NUM_IN_W);

  if (PAD_IN > NUM_IN) begin : g_pad
    assign in_pad = {{((PAD_IN - NUM_IN) * WIDTH){1'b0}}, IN};
  end else begin : g_pad
    assign in_pad = IN;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    localparam int LO    = s * LVL_PER_STG;
    localparam int HI    = (LO + LVL_PER_STG < LEVELS) ? LO + LVL_PER_STG : LEVELS;
    localparam int NLV   = HI - LO;
    localparam int W_IN  = (2**(LEVELS - LO)) * WIDTH;
    localparam int W_OUT = (2**(LEVELS - HI)) * WIDTH;

    logic [W_IN-1:0]        stg_din;
    logic [LEVELS-LO-1:0]   stg_sin;
    stg_ctl_t               stg_cin;
    logic [W_OUT-1:0]       data_d;
    logic [W_OUT-1:0]       data_q;
    stg_ctl_t               ctl_q;
    logic                   ld;

    // Stage source: the padded input port for the first stage, else the previous stage.
    if (s == 0) begin : g_src
      assign stg_din = in_pad;
      assign stg_sin = SEL;
      assign stg_cin = '{valid: in_valid, err: sel_oob};
    end else begin : g_src
      assign stg_din = g_stg[s-1].data_q;
      assign stg_sin = g_stg[s-1].g_sel.sel_q;
      assign stg_cin = g_stg[s-1].ctl_q;
    end

    // Tree levels covered by this stage, each halving the number of words.
    for (genvar i = 0; i < NLV; i++) begin : g_lvl
      localparam int NO = 2**(LEVELS - LO - i - 1);

      logic [2*NO*WIDTH-1:0] lvl_in;
      logic [NO*WIDTH-1:0]   lvl_out;

      if (i == 0) begin : g_head
        assign lvl_in = stg_din;
      end else begin : g_head
        assign lvl_in = g_lvl[i-1].lvl_out;
      end

      for (genvar k = 0; k < NO; k++) begin : g_mux
        mux2to1w #(.WIDTH(WIDTH)) u_mux (
          .IN0 (lvl_in[(2*k)*WIDTH +: WIDTH]),
          .IN1 (lvl_in[(2*k+1)*WIDTH +: WIDTH]),
          .SEL (stg_sin[i]),
          .OUT (lvl_out[k*WIDTH +: WIDTH])
        );
      end
    end

    assign data_d = g_lvl[NLV-1].lvl_out;
    assign ld     = adv & stg_cin.valid;

    // Stage register: valid shifts on every advance, data and err load only with a word.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make each stage capture its predecessor's pre-edge value.
      if (reset) begin
        ctl_q  <= '0;
        data_q <= '0;
      end else begin
        if (adv) ctl_q.valid <= stg_cin.valid;
        if (ld) begin
          ctl_q.err <= stg_cin.err;
          data_q    <= data_d;
        end
      end
    end

    // Select bits still needed by later stages ride along with the data.
    if (HI < LEVELS) begin : g_sel
      logic [LEVELS-HI-1:0] sel_q;

      // Forward the unconsumed select bits with the word they steer.
      always_ff @(posedge clk) begin
        // NOTE: these bits are only consumed alongside a valid word, so they need no reset.
        if (ld) sel_q <= stg_sin[LEVELS-LO-1:NLV];
      end
    end
  end

  assign OUT       = g_stg[STAGES-1].data_q;
  assign out_valid = g_stg[STAGES-1].ctl_q.valid;
  assign sel_err   = g_stg[STAGES-1].ctl_q.err;

`ifdef WMUX_PARITY_EN
  logic par_q;

  // Parity tracks the output register: loads with it, holds with it, resets with it.
  always_ff @(posedge clk) begin
    if (reset)                     par_q <= 1'b0;
    else if (g_stg[STAGES-1].ld)   par_q <= ^g_stg[STAGES-1].data_d;
  end

  assign OUT_PAR = par_q;
`endif

endmodule

// File: tb/tb_word_mux_pipe.sv
// Directed self-checking bench for word_mux_pipe: a 32x32 instance (LPS=2)
// and a 5x8 instance (non power-of-two input count) share clock and reset.
module tb_word_mux_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 32 words of 32 bits
  logic [32*32-1:0] in32;
  logic [4:0]       sel32;
  logic             iv32, ir32, ov32, or32, err32;
  logic [31:0]      out32;
  // 5 words of 8 bits
  logic [5*8-1:0]   in5;
  logic [2:0]       sel5;
  logic             iv5, ir5, ov5, or5, err5;
  logic [7:0]       out5;
`ifdef WMUX_PARITY_EN
  logic             par32, par5;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  word_mux_pipe #(.WIDTH(32), .NUM_IN(32), .LVL_PER_STG(2)) u_dut32 (
    .clk       (clk),
    .reset     (reset),
    .IN        (in32),
    .SEL       (sel32),
    .in_valid  (iv32),
    .in_ready  (ir32),
    .OUT       (out32),
    .out_valid (ov32),
    .out_ready (or32),
    .sel_err   (err32)
`ifdef WMUX_PARITY_EN
    ,
    .OUT_PAR   (par32)
`endif
  );

  word_mux_pipe #(.WIDTH(8), .NUM_IN(5), .LVL_PER_STG(2)) u_dut5 (
    .clk       (clk),
    .reset     (reset),
    .IN        (in5),
    .SEL       (sel5),
    .in_valid  (iv5),
    .in_ready  (ir5),
    .OUT       (out5),
    .out_valid (ov5),
    .out_ready (or5),
    .sel_err   (err5)
`ifdef WMUX_PARITY_EN
    ,
    .OUT_PAR   (par5)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one word into the 32-input DUT and wait (bounded) for its delivery.
  // Entered and left at a falling edge.
  task automatic xfer32(input logic [4:0] s, output logic [31:0] o, output logic e,
                        output logic p, output logic ok);
    ok = 1'b0; o = '0; e = 1'b0; p = 1'b0;
    or32 = 1'b1; sel32 = s; iv32 = 1'b1;
    #1;
    check("x32_ir", ir32, 1);
    @(negedge clk);
    iv32 = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      #1;
      if (ov32) begin
        o = out32; e = err32; ok = 1'b1;
`ifdef WMUX_PARITY_EN
        p = par32;
`endif
      end
      @(negedge clk);
    end
  endtask

  // Same for the 5-input DUT.
  task automatic xfer5(input logic [2:0] s, output logic [7:0] o, output logic e,
                       output logic ok);
    ok = 1'b0; o = '0; e = 1'b0;
    or5 = 1'b1; sel5 = s; iv5 = 1'b1;
    #1;
    @(negedge clk);
    iv5 = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      #1;
      if (ov5) begin
        o = out5; e = err5; ok = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  logic [31:0] o32;
  logic [7:0]  o8;
  logic        e_o, p_o, ok_o;

  // Range vectors for the 5-input DUT, with hand-computed results.
  logic [2:0] r_sel [6] = '{3'd6, 3'd4, 3'd5, 3'd0, 3'd7, 3'd3};
  logic [7:0] r_out [6] = '{8'h00, 8'h14, 8'h00, 8'h10, 8'h00, 8'h13};
  logic       r_err [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int k, rcv, first;
    logic seen;
    logic [31:0] exp_w;

    for (int i = 0; i < 32; i++) in32[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    in5 = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
    sel32 = '0; iv32 = 1'b0; or32 = 1'b1;
    sel5  = '0; iv5  = 1'b0; or5  = 1'b1;

    // 1: reset for two clocks
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ov",  ov32,  0);
    check("rst_out", out32, 0);
    check("rst_err", err32, 0);
    check("rst_ir",  ir32,  1);
    check("rst_ov5", ov5,   0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ir", ir32, 1);

    // 2+3: stream SEL 0..31 with a 5-cycle stall on the output
    k = 0; rcv = 0; first = -1;
    for (int cyc = 0; cyc < 80 && rcv < 32; cyc++) begin
      or32  = !(cyc >= 10 && cyc < 15);
      iv32  = (k < 32);
      sel32 = 5'(k);
      #1;
      exp_w = 32'hA000_0000 + 32'(rcv);
      if (!or32) begin
        check("bp_ov",   ov32,  1);
        check("bp_hold", out32, exp_w);
        check("bp_ir",   ir32,  0);
      end
      if (ov32 && or32) begin
        if (first < 0) first = cyc;
        check("stream_out", out32, exp_w);
        check("stream_err", err32, 0);
        rcv++;
      end
      if (iv32 && ir32) k++;
      @(negedge clk);
    end
    iv32 = 1'b0;
    check("stream_lat",  first, 3);
    check("stream_cnt",  rcv,   32);
    check("stream_sent", k,     32);
    #1;
    check("drain_ov", ov32, 0);
    @(negedge clk);

    // 4: out-of-range selects on the 5-input DUT
    for (int i = 0; i < 6; i++) begin
      xfer5(r_sel[i], o8, e_o, ok_o);
      check("rng_done", ok_o, 1);
      check("rng_out",  o8,   r_out[i]);
      check("rng_err",  e_o,  r_err[i]);
    end

    // 5: two words accepted, then reset before they can reach the output
    or32 = 1'b1; iv32 = 1'b1; sel32 = 5'd1;
    @(negedge clk);
    sel32 = 5'd2;
    @(negedge clk);
    iv32 = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      #1;
      seen = seen | ov32;
      @(negedge clk);
    end
    check("midrst_ov", seen, 0);
    xfer32(5'd9, o32, e_o, p_o, ok_o);
    check("midrst_done", ok_o, 1);
    check("midrst_out",  o32,  32'hA000_0009);

`ifdef WMUX_PARITY_EN
    // 6: parity of the delivered word
    in32[0*32 +: 32] = 32'h0000_0007;
    in32[1*32 +: 32] = 32'h0000_0003;
    xfer32(5'd0, o32, e_o, p_o, ok_o);
    check("par7_out", o32, 32'h0000_0007);
    check("par7",     p_o, 1);
    xfer32(5'd1, o32, e_o, p_o, ok_o);
    check("par3_out", o32, 32'h0000_0003);
    check("par3",     p_o, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
